sweep_sched: RTL and testbench
==============================

# sweep_sched

Frequency-sweep sequencer for the DDS frequency-response path. It steps the DDS frequency word across a programmed list of points. At each point it loads the DDS, waits a settle interval, triggers one measurement, and waits for completion or timeout. It then hands the result to a downstream consumer over a valid/ready port before moving to the next point. It sits between the host register block and the DDS direct-parameter path and measurement unit, all on the DDS clock.

## Interface
- `CNT_WIDTH`, default 16: width of the point count and index.
- `SETTLE_WIDTH`, default 24: width of the settle counter.
- `TIMEOUT_WIDTH`, default 24: width of the measurement timeout counter.
- `clk` in 1: DDS clock; the only clock.
- `rstn` in 1: reset; asynchronous, active-low.
- `cfg_start` in 1: one-cycle start request.
- `cfg_abort` in 1: abort request.
- `cfg_fword_start` in 32: first frequency word.
- `cfg_fword_step` in 32: frequency-word increment per point.
- `cfg_points` in CNT_WIDTH: number of points.
- `cfg_settle` in SETTLE_WIDTH: settle cycles after each load.
- `cfg_timeout` in TIMEOUT_WIDTH: maximum WAIT cycles; 0 disables the timeout.
- `dds_fword` out 32: frequency word presented to the DDS.
- `dds_param_wen` out 1: one-cycle load strobe to the DDS.
- `meas_start` out 1: one-cycle measurement trigger.
- `meas_done` in 1: measurement complete, one-cycle pulse.
- `meas_data` in 32: measurement result; valid when `meas_done` is high.
- `res_valid` out 1: result valid.
- `res_ready` in 1: consumer accepts the result.
- `res_index` out CNT_WIDTH: point index of the result.
- `res_fword` out 32: frequency word of the result.
- `res_data` out 32: captured `meas_data`, or 0 on timeout.
- `res_timeout` out 1: result was produced by timeout.
- `busy` out 1: state is not IDLE.
- `done` out 1: sticky; sweep completed.
- `aborted` out 1: sticky; sweep was aborted.

## Operation
- States: IDLE, LOAD, SETTLE, MEAS, WAIT, REPORT.
- All outputs are registered or decoded from the state register.
- Reset: state IDLE; every output 0; internal counters 0.
- IDLE, on `cfg_start`:
  - latch all `cfg_*` inputs; clear `done` and `aborted`; set index to 0 and fword to `cfg_fword_start`.
  - if `cfg_points` is 0: set `done` and stay in IDLE.
  - otherwise go to LOAD.
- Latched configuration is the only configuration used during a sweep. Changes to `cfg_*` mid-sweep have no effect.
- LOAD: `dds_param_wen` = 1 for this one cycle and `dds_fword` = current fword. Load the settle counter with the latched settle value, then go to SETTLE.
- SETTLE: if the counter is 0, go to MEAS; otherwise decrement. SETTLE lasts `cfg_settle`+1 cycles.
- MEAS: `meas_start` = 1 for one cycle. Load the timeout counter with the latched timeout value, then go to WAIT.
- WAIT:
  - `meas_done` = 1: capture `meas_data`, `res_timeout` = 0, go to REPORT.
  - else, if the timeout is nonzero and the counter is 1: `res_data` = 0, `res_timeout` = 1, go to REPORT.
  - else decrement the counter (no decrement when the timeout is 0).
  - If `meas_done` arrives on the timeout cycle, the done path wins.
- REPORT:
  - `res_valid` = 1; `res_index`, `res_fword`, `res_data` and `res_timeout` stay stable until `res_valid`&&`res_ready`.
  - On handshake, if index = points−1: set `done` and go to IDLE.
  - On handshake otherwise: index+1; fword = fword + step, modulo 2^32 (wrap permitted, no saturation); go to LOAD.
- `dds_fword` holds its last loaded value in every state, including IDLE after completion or abort.
- `meas_done` outside WAIT is ignored.
- `cfg_start` while `busy` is ignored.
- `cfg_abort` in any non-IDLE state:
  - next state is IDLE; `res_valid` drops; set `aborted`.
  - abort has priority over a same-cycle handshake, `meas_done` or timeout.
  - `cfg_abort` in IDLE has no effect.
- `rstn` asserted mid-sweep: immediate return to reset values; no results are emitted.

## Timing
- `cfg_start` sampled at cycle 0 gives:
  - LOAD at cycle 1 (`dds_param_wen` high);
  - SETTLE at cycles 2..S+2, where S = `cfg_settle`;
  - `meas_start` at cycle S+3;
  - WAIT from cycle S+4.
- `meas_done` at cycle t gives `res_valid` at t+1.
- Handshake at cycle r gives the next point's `dds_param_wen` at r+1.
- Timeout T with no done: REPORT begins T cycles after the first WAIT cycle.
- Per-point minimum is S+5 cycles: done arrives on the first WAIT cycle and `res_ready` is held high.
- `busy` falls on the cycle after the final handshake or after abort; `done` rises on that same cycle.

## Test plan
- Basic sweep:
  - stimulus: start=1000, step=500, points=3, settle=4, timeout=0; `meas_done` 2 cycles after each `meas_start` with data=index+0x10; `res_ready` held high.
  - response: three loads with fwords 1000, 1500, 2000; results (0,1000,0x10), (1,1500,0x11), (2,2000,0x12); first `meas_start` at cycle 7; `done`=1 and `busy`=0 after the last handshake.
- Backpressure:
  - stimulus: `res_ready` low for 10 cycles on point 1.
  - response: `res_valid` and all `res_*` fields stable for those 10 cycles; no `dds_param_wen` until the cycle after the handshake.
- Timeout:
  - stimulus: timeout=8, `meas_done` never asserted.
  - response: REPORT 8 cycles after the first WAIT cycle, `res_timeout`=1, `res_data`=0; the sweep continues to the next point.
  - stimulus: done and timeout in the same cycle.
  - response: `res_timeout`=0 with the captured data.
- Wrap and edges:
  - stimulus: start=0xFFFF_FF00, step=0x200, points=2.
  - response: second fword is 0x0000_0100.
  - stimulus: points=0.
  - response: `done`=1, no `dds_param_wen`, `busy` never high.
  - stimulus: settle=0.
  - response: exactly one SETTLE cycle.
- Abort and reset:
  - stimulus: `cfg_abort` during SETTLE, WAIT, and REPORT with `res_ready`=1 in the same cycle.
  - response: IDLE next cycle, `aborted`=1, no handshake counted; a new `cfg_start` clears `aborted` and restarts at index 0.
  - stimulus: `rstn` pulsed mid-WAIT.
  - response: all outputs 0 immediately.
  - stimulus: `cfg_start` while busy.
  - response: ignored.

Source files
------------

// File: rtl/sweep_sched.sv
// Frequency-sweep sequencer: loads each DDS frequency point, settles, triggers one
// measurement, then hands the result (or a timeout marker) downstream over valid/ready.
module sweep_sched #(
  parameter int CNT_WIDTH     = 16,
  parameter int SETTLE_WIDTH  = 24,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic [31:0]              cfg_fword_start,
  input  logic [31:0]              cfg_fword_step,
  input  logic [CNT_WIDTH-1:0]     cfg_points,
  input  logic [SETTLE_WIDTH-1:0]  cfg_settle,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  output logic [31:0]              dds_fword,
  output logic                     dds_param_wen,
  output logic                     meas_start,
  input  logic                     meas_done,
  input  logic [31:0]              meas_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [CNT_WIDTH-1:0]     res_index,
  output logic [31:0]              res_fword,
  output logic [31:0]              res_data,
  output logic                     res_timeout,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, MEAS, WAIT, REPORT} state_t;

  state_t                   state;
  logic [31:0]              lat_step, fword;
  logic [CNT_WIDTH-1:0]     lat_points, idx;
  logic [SETTLE_WIDTH-1:0]  lat_settle, settle_cnt;
  logic [TIMEOUT_WIDTH-1:0] lat_timeout, to_cnt;
  logic                     last_pt;

  assign dds_param_wen = (state == LOAD);
  assign meas_start    = (state == MEAS);
  assign res_valid     = (state == REPORT);
  assign busy          = (state != IDLE);
  assign res_index     = idx;
  assign res_fword     = fword;
  assign last_pt       = (idx == lat_points - CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      lat_step    <= '0;
      lat_points  <= '0;
      lat_settle  <= '0;
      lat_timeout <= '0;
      fword       <= '0;
      idx         <= '0;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      dds_fword   <= '0;
      res_data    <= '0;
      res_timeout <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else if (cfg_abort && state != IDLE) begin
      // abort outranks any same-cycle handshake, done or timeout
      state   <= IDLE;
      aborted <= 1'b1;
    end else begin
      case (state)
        IDLE: if (cfg_start) begin
          lat_step    <= cfg_fword_step;
          lat_points  <= cfg_points;
          lat_settle  <= cfg_settle;
          lat_timeout <= cfg_timeout;
          idx         <= '0;
          fword       <= cfg_fword_start;
          aborted     <= 1'b0;
          done        <= (cfg_points == '0);
          if (cfg_points != '0) begin
            dds_fword <= cfg_fword_start;
            state     <= LOAD;
          end
        end
        LOAD: begin
          settle_cnt <= lat_settle;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= MEAS;
          else settle_cnt <= settle_cnt - SETTLE_WIDTH'(1);
        end
        MEAS: begin
          to_cnt <= lat_timeout;
          state  <= WAIT;
        end
        WAIT: begin
          if (meas_done) begin
            res_data    <= meas_data;
            res_timeout <= 1'b0;
            state       <= REPORT;
          end else if (lat_timeout != '0 && to_cnt == TIMEOUT_WIDTH'(1)) begin
            res_data    <= '0;
            res_timeout <= 1'b1;
            state       <= REPORT;
          end else if (lat_timeout != '0) begin
            to_cnt <= to_cnt - TIMEOUT_WIDTH'(1);
          end
        end
        REPORT: if (res_ready) begin
          if (last_pt) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            // dds_fword follows fword into LOAD so the word is valid on the strobe cycle
            idx       <= idx + CNT_WIDTH'(1);
            fword     <= fword + lat_step;
            dds_fword <= fword + lat_step;
            state     <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sweep_sched.sv
// Directed and randomized sweeps checked against a cycle schedule derived from the timing rules.
module tb_sweep_sched;
  localparam int CW = 16, SW = 24, TW = 24, MAXP = 8;

  logic          clk = 1'b0, rstn = 1'b1;
  logic          cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [31:0]   cfg_fword_start = '0, cfg_fword_step = '0;
  logic [CW-1:0] cfg_points = '0;
  logic [SW-1:0] cfg_settle = '0;
  logic [TW-1:0] cfg_timeout = '0;
  logic [31:0]   dds_fword;
  logic          dds_param_wen, meas_start;
  logic          meas_done = 1'b0;
  logic [31:0]   meas_data = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [CW-1:0] res_index;
  logic [31:0]   res_fword, res_data;
  logic          res_timeout, busy, done, aborted;

  int          checks = 0, errs = 0;
  logic [31:0] last_fword = '0;
  logic        exp_done = 1'b0, exp_aborted = 1'b0;

  // per-point schedule: load, meas_start, first WAIT, report start, handshake cycles
  int          L[MAXP], M[MAXP], W[MAXP], R[MAXP], H[MAXP];
  logic        hit[MAXP];
  logic [31:0] dat[MAXP], fw[MAXP];

  always #5 clk = ~clk;

  sweep_sched #(.CNT_WIDTH(CW), .SETTLE_WIDTH(SW), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_fword_start(cfg_fword_start), .cfg_fword_step(cfg_fword_step),
    .cfg_points(cfg_points), .cfg_settle(cfg_settle), .cfg_timeout(cfg_timeout),
    .dds_fword(dds_fword), .dds_param_wen(dds_param_wen), .meas_start(meas_start),
    .meas_done(meas_done), .meas_data(meas_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_index(res_index), .res_fword(res_fword),
    .res_data(res_data), .res_timeout(res_timeout), .busy(busy), .done(done),
    .aborted(aborted)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " done"}, 64'(done), 64'(0));
    chk({tag, " aborted"}, 64'(aborted), 64'(0));
    chk({tag, " wen"}, 64'(dds_param_wen), 64'(0));
    chk({tag, " mstart"}, 64'(meas_start), 64'(0));
    chk({tag, " valid"}, 64'(res_valid), 64'(0));
    chk({tag, " fword"}, 64'(dds_fword), 64'(0));
    chk({tag, " rindex"}, 64'(res_index), 64'(0));
    chk({tag, " rfword"}, 64'(res_fword), 64'(0));
    chk({tag, " rdata"}, 64'(res_data), 64'(0));
    chk({tag, " rtimeout"}, 64'(res_timeout), 64'(0));
  endtask

  // d: meas_done delay after meas_start (<=0: never); abort_at: cycle of cfg_abort (<0: none)
  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] st, input int np,
                           input int s, input int t, input int d, input int stall_pt,
                           input int stall_len, input int abort_at, input bit basic);
    int prev, end_c;
    bit ab;
    prev = 0;
    for (int i = 0; i < np; i++) begin
      L[i]   = prev + 1;
      M[i]   = L[i] + s + 2;
      W[i]   = M[i] + 1;
      hit[i] = (d > 0) && (t == 0 || d <= t);
      R[i]   = hit[i] ? M[i] + d + 1 : W[i] + t;
      H[i]   = R[i] + ((i == stall_pt) ? stall_len : 0);
      fw[i]  = fs + st * 32'(i);
      dat[i] = basic ? 32'(i + 16) : $urandom;
      prev   = H[i];
    end
    ab    = (abort_at >= 0);
    end_c = (np == 0) ? 0 : H[np-1];
    if (ab && abort_at < end_c) end_c = abort_at;

    for (int c = 0; c <= end_c + 4; c++) begin
      logic e_wen, e_ms, e_v, e_busy, e_done, e_ab, dn, in_wait, rdy;
      logic [31:0] e_fw, dd;
      int vp;
      @(negedge clk);
      e_wen = 1'b0; e_ms = 1'b0; e_v = 1'b0; vp = 0; e_fw = last_fword;
      dn = 1'b0; dd = $urandom; in_wait = 1'b0; rdy = 1'($urandom_range(0, 1));
      for (int i = 0; i < np; i++) begin
        if (L[i] == c && c <= end_c) e_wen = 1'b1;
        if (L[i] <= c && L[i] <= end_c) e_fw = fw[i];
        if (M[i] == c && c <= end_c) e_ms = 1'b1;
        if (R[i] <= c && c <= H[i] && c <= end_c) begin e_v = 1'b1; vp = i; end
        if (c >= W[i] && c < R[i]) in_wait = 1'b1;
        if (d > 0 && c == M[i] + d) begin dn = 1'b1; dd = dat[i]; end
        if (c >= R[i] && c <= H[i]) rdy = (c == H[i]);
      end
      e_busy = (np > 0) && (c >= 1) && (c <= end_c);
      e_done = (c == 0) ? exp_done : (!ab && (np == 0 || c > end_c));
      e_ab   = (c == 0) ? exp_aborted : (ab && c > end_c);

      chk($sformatf("c%0d busy", c), 64'(busy), 64'(e_busy));
      chk($sformatf("c%0d done", c), 64'(done), 64'(e_done));
      chk($sformatf("c%0d aborted", c), 64'(aborted), 64'(e_ab));
      chk($sformatf("c%0d wen", c), 64'(dds_param_wen), 64'(e_wen));
      chk($sformatf("c%0d mstart", c), 64'(meas_start), 64'(e_ms));
      chk($sformatf("c%0d fword", c), 64'(dds_fword), 64'(e_fw));
      chk($sformatf("c%0d valid", c), 64'(res_valid), 64'(e_v));
      if (e_v) begin
        chk($sformatf("c%0d rindex", c), 64'(res_index), 64'(vp));
        chk($sformatf("c%0d rfword", c), 64'(res_fword), 64'(fw[vp]));
        chk($sformatf("c%0d rdata", c), 64'(res_data), 64'(hit[vp] ? dat[vp] : 32'd0));
        chk($sformatf("c%0d rtimeout", c), 64'(res_timeout), 64'(!hit[vp]));
      end

      cfg_start = (c == 0) || (e_busy && $urandom_range(0, 7) == 0);
      if (c == 0) begin
        cfg_fword_start = fs; cfg_fword_step = st; cfg_points = CW'(np);
        cfg_settle = SW'(s); cfg_timeout = TW'(t);
      end else begin
        cfg_fword_start = $urandom; cfg_fword_step = $urandom;
        cfg_points = CW'($urandom_range(0, 5)); cfg_settle = SW'($urandom_range(0, 6));
        cfg_timeout = TW'($urandom_range(0, 9));
      end
      cfg_abort = (c == abort_at) || (c > end_c && $urandom_range(0, 3) == 0);
      meas_done = dn || (!in_wait && $urandom_range(0, 3) == 0);
      meas_data = dd;
      res_ready = rdy;
    end
    last_fword = (np == 0) ? last_fword : last_fword;
    for (int i = 0; i < np; i++) if (L[i] <= end_c) last_fword = fw[i];
    exp_done    = !ab;
    exp_aborted = ab;
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    run_sweep(32'd1000, 32'd500, 3, 4, 0, 2, -1, 0, -1, 1'b1);       // basic
    run_sweep($urandom, $urandom, 3, 3, 0, 1, 1, 10, -1, 1'b0);      // backpressure on point 1
    run_sweep($urandom, $urandom, 2, 2, 8, -1, -1, 0, -1, 1'b0);     // timeout, no done
    run_sweep($urandom, $urandom, 2, 1, 5, 5, -1, 0, -1, 1'b0);      // done on timeout cycle
    run_sweep(32'hFFFF_FF00, 32'h200, 2, 1, 0, 1, -1, 0, -1, 1'b0);  // fword wrap
    run_sweep($urandom, $urandom, 0, 3, 0, 1, -1, 0, -1, 1'b0);      // zero points
    run_sweep($urandom, $urandom, 2, 0, 0, 1, -1, 0, -1, 1'b0);      // zero settle
    run_sweep($urandom, $urandom, 3, 5, 0, 2, -1, 0, 3, 1'b0);       // abort in SETTLE
    run_sweep($urandom, $urandom, 2, 1, 0, 2, -1, 0, -1, 1'b0);      // restart clears aborted
    run_sweep($urandom, $urandom, 2, 1, 0, 6, -1, 0, 7, 1'b0);       // abort in WAIT
    run_sweep($urandom, $urandom, 3, 1, 0, 1, 0, 3, 9, 1'b0);        // abort on handshake cycle
    run_sweep($urandom, $urandom, 2, 2, 4, 2, -1, 0, -1, 1'b0);

    // reset pulsed mid-WAIT
    cfg_abort = 1'b0; meas_done = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    cfg_fword_start = 32'h1234; cfg_fword_step = 32'd1; cfg_points = CW'(3);
    cfg_settle = SW'(2); cfg_timeout = '0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("midwait busy", 64'(busy), 64'(1));
    chk("midwait fword", 64'(dds_fword), 64'(32'h1234));
    #2 rstn = 1'b0;
    #1 chk_all_zero("midwait reset");
    @(negedge clk);
    rstn = 1'b1;
    last_fword = '0; exp_done = 1'b0; exp_aborted = 1'b0;

    for (int k = 0; k < 6; k++) begin
      int np, s, t, d, sp, sl;
      np = int'($urandom_range(1, 5));
      s  = int'($urandom_range(0, 6));
      t  = int'($urandom_range(0, 10));
      if (t == 0) d = int'($urandom_range(1, 6));
      else d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, t + 2));
      sp = int'($urandom_range(0, np - 1));
      sl = int'($urandom_range(0, 4));
      run_sweep($urandom, $urandom, np, s, t, d, sp, sl, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
